camera_update_scheduler: RTL and testbench
==========================================

Name: camera_update_scheduler

Overview:
- Arbitrates runtime camera register writes from several requesters (exposure control, gain control, debug UART, etc.) and serialises them into the single register-write path feeding the I2C camera configurator.
- Buffers accepted writes in a small FIFO and issues them one at a time.
- Waits for each I2C transaction to start and finish (bus_active) and enforces an inter-write gap before issuing the next write.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- FIFO_DEPTH, 8, pending-write FIFO entries (power of two)
- GAP_CYCLES, 64, idle clk_camera cycles required between bus_active falling and the next issue
- START_TIMEOUT, 1024, cycles to wait for bus_active to rise after a write is accepted

Ports:
- clk_camera  input  1  camera clock domain clock
- sys_rst_camera  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester write request
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_addr  input  16*NUM_REQ  camera register address, requester i in bits [16i+15:16i]
- req_data  input  8*NUM_REQ  register value, requester i in bits [8i+7:8i]
- wr_valid  output  1  write presented to configurator
- wr_ready  input  1  configurator accepts write
- wr_reg  output  24  {addr[15:0], data[7:0]}
- bus_active  input  1  I2C transaction in progress
- busy  output  1  FIFO non-empty or FSM not in IDLE
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- timeout_err  output  1  sticky; set on start timeout, cleared only by reset

Behaviour:
- Reset values (asynchronous): req_ready=0, wr_valid=0, wr_reg=0, busy=0, fifo_count=0, timeout_err=0, FIFO empty, round-robin pointer=0, FSM=IDLE, all counters=0.
- Arbiter (combinational grant, registered pointer):
  - Among asserted req_valid, grant the lowest index >= pointer, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only if the FIFO is not full at the start of the cycle; there is no full-bypass, even with a simultaneous pop.
  - On handshake (req_valid[g] && req_ready[g]), push {addr,data} and set pointer = (g+1) mod NUM_REQ.
  - With no handshake the pointer holds.
  - At most one push per cycle.
- FIFO:
  - Simultaneous push and pop are allowed (count unchanged).
  - Pointers wrap at FIFO_DEPTH.
  - fifo_count reflects the registered occupancy.
- Issue FSM:
  - IDLE:
    - If the FIFO is non-empty and bus_active=0: wr_valid=1 and wr_reg=head, registered one cycle after entry; go to ISSUE.
    - If bus_active=1 (external configurator still running init), stay in IDLE.
  - ISSUE:
    - Hold wr_valid and wr_reg stable until wr_ready.
    - On wr_valid && wr_ready: pop the FIFO, drop wr_valid next cycle, clear the timer, go to WAIT_START.
  - WAIT_START:
    - bus_active=1 -> WAIT_DONE.
    - If the timer reaches START_TIMEOUT-1 with bus_active still 0: set timeout_err, go to GAP. The write is dropped, not retried.
  - WAIT_DONE: on bus_active=0, clear the gap counter and go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. Minimum spacing from bus_active falling to the next wr_valid is GAP_CYCLES+1 cycles.
- busy = (fifo_count != 0) || (state != IDLE).
- Latency: a request accepted into an empty FIFO with the FSM idle reaches wr_valid 2 cycles after the handshake (push cycle, then IDLE decision).
- Ordering: issue order equals FIFO acceptance order, with no coalescing of same-address writes.
- Reset mid-operation: everything returns to reset values asynchronously, and pending FIFO writes are discarded. A configurator transaction already in flight is not aborted; after reset deassertion, IDLE waits for bus_active=0 before issuing.

Test Plan:
- Single write:
  - Stimulus: requester 1 sends addr 16'h3501, data 8'h0A; wr_ready tied 1; bus_active pulses high 3 cycles after issue for 20 cycles.
  - Required: wr_reg=24'h35010A; wr_valid high exactly 1 cycle; next issue blocked for GAP_CYCLES after bus_active falls; busy returns to 0.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold req_valid continuously with distinct data.
  - Required: grant order 0,1,2,3,0,1,...; each req_ready one-hot; FIFO fills to 8 and req_ready stays 0 while full.
- Full plus simultaneous pop:
  - Stimulus: FIFO at 8 while a pop occurs in the same cycle.
  - Required: no push that cycle; fifo_count goes 8->7; push succeeds on the next cycle.
- Backpressure:
  - Stimulus: wr_ready held 0 for 10 cycles.
  - Required: wr_valid and wr_reg stable throughout; FIFO not popped until wr_ready=1.
- Start timeout:
  - Stimulus: bus_active never rises after acceptance, with START_TIMEOUT=16.
  - Required: timeout_err=1 after 16 cycles; the write is dropped; the next FIFO entry is issued after the gap; timeout_err stays 1.
- Async reset mid-WAIT_DONE with 3 entries queued:
  - Required: all outputs reset immediately without waiting for a clock edge; fifo_count=0; no wr_valid until bus_active=0 after reset release.

Source files
------------

// File: rtl/camera_update_scheduler.sv
// Camera register-write scheduler: round-robin arbitration of several
// requesters into a pending-write FIFO, then one-at-a-time issue towards the
// I2C configurator with start timeout and inter-write gap enforcement.
module camera_update_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned GAP_CYCLES    = 64,
    parameter int unsigned START_TIMEOUT = 1024
) (
    input  logic                          clk_camera,
    input  logic                          sys_rst_camera,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [16*NUM_REQ-1:0]         req_addr,
    input  logic [8*NUM_REQ-1:0]          req_data,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [23:0]                   wr_reg,
    input  logic                          bus_active,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout_err
);

    localparam int unsigned RW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CAND_W = RW + 1;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned TW     = $clog2(START_TIMEOUT) + 1;
    localparam int unsigned GW     = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t          state;
    logic [RW-1:0]   rr_ptr;
    logic [RW-1:0]   grant_idx;
    logic            grant_found;
    logic [CAND_W-1:0] cand;
    logic [23:0]     push_word;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [23:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gap_cnt;

    // Round-robin grant: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (req_valid[cand[RW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[RW-1:0];
            end
        end
    end

    // Payload of the granted requester.
    always_comb begin
        push_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == RW'(i)) begin
                push_word = {req_addr[i*16 +: 16], req_data[i*8 +: 8]};
            end
        end
    end

    // Accept only when the FIFO has room at the start of the cycle; a
    // same-cycle pop does not free a slot for the push.
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign push      = grant_found && !fifo_full && !sys_rst_camera;
    assign pop       = (state == ST_ISSUE) && wr_valid && wr_ready;
    assign req_ready = push ? (NUM_REQ'(1) << grant_idx) : '0;

    assign fifo_count = count;
    assign busy       = (count != '0) || (state != ST_IDLE);

    // Round-robin pointer advances past the winner on each accepted write.
    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (grant_idx == RW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_camera) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue FSM: present head, wait for the I2C transaction, then hold off.
    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            state       <= ST_IDLE;
            wr_valid    <= 1'b0;
            wr_reg      <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if ((count != '0) && !bus_active) begin
                        wr_valid <= 1'b1;
                        wr_reg   <= mem[rd_ptr];
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        timer    <= '0;
                        state    <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (bus_active) begin
                        state <= ST_WAIT_DONE;
                    end else if (timer == TW'(START_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= ST_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus_active) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_update_scheduler.sv
// Directed bench for camera_update_scheduler with hand-computed expectations.
module tb_camera_update_scheduler;

    localparam int unsigned NUM_REQ       = 4;
    localparam int unsigned FIFO_DEPTH    = 8;
    localparam int unsigned GAP_CYCLES    = 8;
    localparam int unsigned START_TIMEOUT = 16;

    logic                        clk;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [16*NUM_REQ-1:0]       req_addr;
    logic [8*NUM_REQ-1:0]        req_data;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [23:0]                 wr_reg;
    logic                        bus_active;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        timeout_err;

    int checks;
    int failures;
    int n;

    camera_update_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .GAP_CYCLES   (GAP_CYCLES),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk_camera    (clk),
        .sys_rst_camera(rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_reg        (wr_reg),
        .bus_active    (bus_active),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [7:0] d);
        req_addr[i*16 +: 16] = a;
        req_data[i*8 +: 8]   = d;
    endtask

    // Count rising edges until wr_valid is seen, bounded.
    task automatic wait_issue(output int edges);
        edges = 0;
        while (edges < 40) begin
            tick();
            edges++;
            if (wr_valid) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = '1;
        req_addr   = '0;
        req_data   = '0;
        wr_ready   = 1'b1;
        bus_active = 1'b0;

        // Reset state (requests present must not be accepted during reset).
        #3;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_wr_valid", 32'(wr_valid), 32'h0);
        check("rst_wr_reg", 32'(wr_reg), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;

        // Single write from requester 1.
        set_req(1, 16'h3501, 8'h0A);
        req_valid = 4'b0010;
        #1;
        check("single_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("single_count_after_push", 32'(fifo_count), 32'h1);
        check("single_no_early_valid", 32'(wr_valid), 32'h0);
        check("single_busy", 32'(busy), 32'h1);
        tick();
        check("single_wr_valid", 32'(wr_valid), 32'h1);
        check("single_wr_reg", 32'(wr_reg), 32'h35010A);
        tick();
        check("single_valid_one_cycle", 32'(wr_valid), 32'h0);
        check("single_popped", 32'(fifo_count), 32'h0);
        tick();
        bus_active = 1'b1;
        tick();
        set_req(2, 16'h3502, 8'h10);
        req_valid = 4'b0100;
        #1;
        check("second_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        repeat (18) tick();
        check("blocked_while_bus_active", 32'(wr_valid), 32'h0);
        check("second_queued", 32'(fifo_count), 32'h1);
        bus_active = 1'b0;
        wait_issue(n);
        check("gap_spacing_edges", 32'(n), 32'(GAP_CYCLES + 2));
        check("second_wr_reg", 32'(wr_reg), 32'h350210);
        tick();
        bus_active = 1'b1;
        repeat (3) tick();
        bus_active = 1'b0;
        repeat (GAP_CYCLES + 3) tick();
        check("single_busy_clear", 32'(busy), 32'h0);
        check("single_no_timeout", 32'(timeout_err), 32'h0);

        // Round-robin fill with the issue path held off by bus_active.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        bus_active = 1'b1;
        wr_ready   = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'(16'h1000 + i), 8'(8'hA0 + i));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
            tick();
        end
        #1;
        check("rr_full_count", 32'(fifo_count), 32'h8);
        check("rr_full_no_ready", 32'(req_ready), 32'h0);
        tick();
        check("rr_full_hold", 32'(fifo_count), 32'h8);

        // Backpressure: wr_ready low, head must stay presented unchanged.
        wr_ready   = 1'b0;
        bus_active = 1'b0;
        tick();
        check("bp_wr_valid", 32'(wr_valid), 32'h1);
        check("bp_head", 32'(wr_reg), 32'h1000A0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold_valid", 32'(wr_valid), 32'h1);
            check("bp_hold_reg", 32'(wr_reg), 32'h1000A0);
            check("bp_no_pop", 32'(fifo_count), 32'h8);
        end

        // Full with simultaneous pop: no push this cycle, push next cycle.
        set_req(0, 16'h1000, 8'hB0);
        wr_ready = 1'b1;
        #1;
        check("full_pop_no_ready", 32'(req_ready), 32'h0);
        tick();
        check("full_pop_count", 32'(fifo_count), 32'h7);
        check("full_pop_valid_drop", 32'(wr_valid), 32'h0);
        check("full_pop_next_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("full_pop_refill", 32'(fifo_count), 32'h8);

        // Start timeout: bus_active never rises after the pop.
        check("to_not_yet", 32'(timeout_err), 32'h0);
        repeat (14) tick();
        check("to_edge_minus_one", 32'(timeout_err), 32'h0);
        tick();
        check("to_set", 32'(timeout_err), 32'h1);
        wait_issue(n);
        check("to_gap_edges", 32'(n), 32'(GAP_CYCLES + 1));
        check("to_next_head", 32'(wr_reg), 32'h1001A1);
        tick();
        check("to_dropped_count", 32'(fifo_count), 32'h7);
        check("to_sticky", 32'(timeout_err), 32'h1);

        // Async reset in WAIT_DONE with entries queued.
        bus_active = 1'b1;
        repeat (4) tick();
        check("pre_rst_busy", 32'(busy), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_fifo_count", 32'(fifo_count), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_wr_reg", 32'(wr_reg), 32'h0);
        check("arst_timeout_err", 32'(timeout_err), 32'h0);
        check("arst_wr_valid", 32'(wr_valid), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        set_req(2, 16'h4000, 8'h55);
        req_valid = 4'b0100;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        repeat (5) tick();
        check("post_rst_wait_bus", 32'(wr_valid), 32'h0);
        check("post_rst_count", 32'(fifo_count), 32'h1);
        bus_active = 1'b0;
        wait_issue(n);
        check("post_rst_issue_edges", 32'(n), 32'h1);
        check("post_rst_wr_reg", 32'(wr_reg), 32'h400055);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
